// File: rtl/vga_timing_receiver_pkg.sv
// Shared timing constants, FSM state encodings and colour codes for the VGA timing receiver.
package vga_timing_receiver_pkg;

  localparam int HS_Ts  = 800;
  localparam int HS_Tpw = 96;
  localparam int HS_Tbp = 48;
  localparam int HS_Tfp = 16;
  localparam int H_ACTIVE = 640;

  localparam int VS_lines_total = 521;
  localparam int VS_lines_pw    = 2;
  localparam int VS_lines_bp    = 29;
  localparam int VS_lines_fp    = 10;
  localparam int V_ACTIVE       = 480;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } rx_state_t;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_WHITE = 3'b111;

  function automatic logic in_range(input logic [CNT_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Rise/fall pulse detector for an active-low sync line; the history register idles high.
module vga_sync_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic sync_in,
  output logic rise,
  output logic fall
);

  logic sync_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) sync_q <= 1'b1;
    else       sync_q <= sync_in;
  end

  assign rise = sync_in & ~sync_q;
  assign fall = ~sync_in & sync_q;

endmodule

// File: rtl/vga_timing_receiver.sv
// Recovers H/V position from Hsync/Vsync, measures line/frame timing and locks on stable frames.
// Optional VGA_RX_CHECKSUM_EN adds a per-frame 16-bit sum of the valid pixel stream.
//
// state   | meaning
// SEARCH  | waiting for a Vsync rise to start measuring
// MEASURE | capturing line period, Hsync width and lines per frame
// VERIFY  | comparing each line/frame with the captured values
// LOCKED  | timing stable, comparisons continue
module vga_timing_receiver
  import vga_timing_receiver_pkg::*;
#(
  parameter int H_ACT_START = HS_Tbp,
  parameter int H_ACT_END   = HS_Tbp + H_ACTIVE - 1,
  parameter int V_ACT_START = VS_lines_bp,
  parameter int V_ACT_END   = VS_lines_bp + V_ACTIVE - 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iHsync,
  input  logic             iVsync,
  input  logic [2:0]       iVGA_RGB,
  output logic [CNT_W-1:0] oHcounter,
  output logic [CNT_W-1:0] oVcounter,
  output logic [2:0]       oVGA_RGB,
  output logic             oPixelValid,
  output logic [CNT_W-1:0] oLinePeriod,
  output logic [CNT_W-1:0] oHsyncWidth,
  output logic [CNT_W-1:0] oFrameLines,
  output logic             oLocked,
  output logic             oErr
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0]      oFrameChecksum
`endif
);

  localparam logic [1:0] LOCK_N = 2'(LOCK_FRAMES);

  rx_state_t state_q, state_n;
  logic [1:0] match_q, match_n;
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic vs_pend;
  logic [CNT_W-1:0] hcnt_n, vcnt_n, hcnt_p1, vcnt_p1, wcnt_q, wcnt_n;
  logic timeout, line_bad, frame_bad;
  logic err_n, cap_line, cap_frame;

  vga_sync_edge_detect u_hs_edge (
    .Clock(Clock), .Reset(Reset), .sync_in(iHsync), .rise(hs_rise), .fall(hs_fall)
  );

  vga_sync_edge_detect u_vs_edge (
    .Clock(Clock), .Reset(Reset), .sync_in(iVsync), .rise(vs_rise), .fall(vs_fall)
  );

  assign hcnt_p1   = oHcounter + 10'd1;
  assign vcnt_p1   = oVcounter + 10'd1;
  assign timeout   = (oHcounter == CNT_MAX) || (oVcounter == CNT_MAX);
  assign line_bad  = hs_rise && ((hcnt_p1 != oLinePeriod) || (wcnt_q != oHsyncWidth));
  assign frame_bad = vs_rise && (vcnt_p1 != oFrameLines);

  always_comb begin
    hcnt_n = oHcounter;
    vcnt_n = oVcounter;
    wcnt_n = wcnt_q;
    if (hs_rise) hcnt_n = '0;
    else if (oHcounter != CNT_MAX) hcnt_n = hcnt_p1;
    if (hs_rise) begin
      if (vs_pend || vs_rise) vcnt_n = '0;
      else if (oVcounter != CNT_MAX) vcnt_n = vcnt_p1;
    end
    if (hs_fall) wcnt_n = 10'd1;
    else if (!iHsync && (wcnt_q != CNT_MAX)) wcnt_n = wcnt_q + 10'd1;
  end

  always_comb begin
    state_n   = state_q;
    match_n   = match_q;
    err_n     = 1'b0;
    cap_line  = 1'b0;
    cap_frame = 1'b0;
    case (state_q)
      SEARCH: if (vs_rise) state_n = MEASURE;
      MEASURE: begin
        if (timeout) begin
          err_n   = 1'b1;
          state_n = SEARCH;
        end else begin
          cap_line = hs_rise;
          if (vs_rise) begin
            cap_frame = 1'b1;
            match_n   = 2'd1;
            state_n   = (LOCK_FRAMES == 1) ? LOCKED : VERIFY;
          end
        end
      end
      VERIFY, LOCKED: begin
        if (timeout || line_bad || frame_bad) begin
          err_n   = 1'b1;
          state_n = SEARCH;
        end else if (vs_rise && (state_q == VERIFY)) begin
          match_n = match_q + 2'd1;
          if (match_n >= LOCK_N) state_n = LOCKED;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= SEARCH;
      match_q     <= '0;
      vs_pend     <= 1'b0;
      wcnt_q      <= '0;
      oHcounter   <= '0;
      oVcounter   <= '0;
      oVGA_RGB    <= '0;
      oPixelValid <= 1'b0;
      oLinePeriod <= '0;
      oHsyncWidth <= '0;
      oFrameLines <= '0;
      oLocked     <= 1'b0;
      oErr        <= 1'b0;
    end else begin
      state_q   <= state_n;
      match_q   <= match_n;
      wcnt_q    <= wcnt_n;
      oHcounter <= hcnt_n;
      oVcounter <= vcnt_n;
      oVGA_RGB  <= iVGA_RGB;
      // a Vsync high that ends before any Hsync rise is a glitch, not a frame start
      if (hs_rise || vs_fall) vs_pend <= 1'b0;
      else if (vs_rise)       vs_pend <= 1'b1;
      if (cap_line) begin
        oLinePeriod <= hcnt_p1;
        oHsyncWidth <= wcnt_q;
      end
      if (cap_frame) oFrameLines <= vcnt_p1;
      oErr        <= err_n;
      oLocked     <= (state_n == LOCKED);
      oPixelValid <= (state_n == LOCKED) && in_range(hcnt_n, H_ACT_START, H_ACT_END)
                     && in_range(vcnt_n, V_ACT_START, V_ACT_END);
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] csum_acc;

  // the accumulator is held at zero while unlocked so a frame cut short by an error never leaks into the next sum
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      csum_acc       <= '0;
      oFrameChecksum <= '0;
    end else if (vs_rise && (state_q == LOCKED)) begin
      oFrameChecksum <= csum_acc;
      csum_acc       <= '0;
    end else if (!oLocked) begin
      csum_acc <= '0;
    end else if (oPixelValid) begin
      csum_acc <= csum_acc + {13'b0, oVGA_RGB};
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver using a reduced 100x40 timing so several frames fit the run.
module tb_vga_timing_receiver;
  import vga_timing_receiver_pkg::*;

  localparam int HHIGH  = 88;
  localparam int HPW    = 12;
  localparam int LINE   = HHIGH + HPW;
  localparam int FLINES = 40;
  localparam int VPW    = 2;
  localparam int HA0 = 8, HA1 = 71, VA0 = 3, VA1 = 34;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic iHsync, iVsync;
  logic [2:0] iVGA_RGB;
  logic [9:0] oHcounter, oVcounter, oLinePeriod, oHsyncWidth, oFrameLines;
  logic [2:0] oVGA_RGB;
  logic oPixelValid, oLocked, oErr;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] oFrameChecksum;
`endif

  always #5 Clock = ~Clock;

  vga_timing_receiver #(
    .H_ACT_START(HA0), .H_ACT_END(HA1), .V_ACT_START(VA0), .V_ACT_END(VA1), .LOCK_FRAMES(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iHsync(iHsync), .iVsync(iVsync), .iVGA_RGB(iVGA_RGB),
    .oHcounter(oHcounter), .oVcounter(oVcounter), .oVGA_RGB(oVGA_RGB),
    .oPixelValid(oPixelValid), .oLinePeriod(oLinePeriod), .oHsyncWidth(oHsyncWidth),
    .oFrameLines(oFrameLines), .oLocked(oLocked), .oErr(oErr)
`ifdef VGA_RX_CHECKSUM_EN
    , .oFrameChecksum(oFrameChecksum)
`endif
  );

  typedef enum int {EV_LOCK, EV_ERR, EV_PV_RISE, EV_PV_FALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int h;
    int v;
    int rgb;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int failures = 0;
  bit exp_locked = 1'b0;
  int exp_sum = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int h, input int v, input int rgb);
    ev_t e;
    e.kind = k; e.h = h; e.v = v; e.rgb = rgb;
    exp_q.push_back(e);
  endtask

  function automatic logic [2:0] pix(input int c, input int l);
    return 3'((c + l) % 8);
  endfunction

  task automatic drive(input logic hs, input logic vs, input logic [2:0] rgb);
    @(negedge Clock);
    iHsync = hs; iVsync = vs; iVGA_RGB = rgb;
  endtask

  task automatic gen_line(input int l, input int high_len, input bit err_after);
    logic vs;
    vs = (l < FLINES - VPW);
    if (exp_locked && l >= VA0 && l <= VA1) begin
      push_ev(EV_PV_RISE, HA0, l, int'(pix(HA0, l)));
      push_ev(EV_PV_FALL, HA1 + 1, l, 0);
      for (int c = HA0; c <= HA1; c++) exp_sum += int'(pix(c, l));
    end
    if (err_after) begin
      push_ev(EV_ERR, 1023, l, 0);
      exp_locked = 1'b0;
    end
    for (int c = 0; c < high_len; c++) drive(1'b1, vs, pix(c, l));
    for (int k = 0; k < HPW; k++) drive(1'b0, vs, RGB_BLACK);
  endtask

  task automatic gen_frame();
    for (int l = 0; l < FLINES; l++) gen_line(l, HHIGH, 1'b0);
  endtask

  task automatic pre_sync();
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, RGB_BLACK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hcnt"}, oHcounter, 0);
    check({tag, "_vcnt"}, oVcounter, 0);
    check({tag, "_rgb"}, oVGA_RGB, 0);
    check({tag, "_pv"}, oPixelValid, 0);
    check({tag, "_period"}, oLinePeriod, 0);
    check({tag, "_width"}, oHsyncWidth, 0);
    check({tag, "_lines"}, oFrameLines, 0);
    check({tag, "_locked"}, oLocked, 0);
    check({tag, "_err"}, oErr, 0);
`ifdef VGA_RX_CHECKSUM_EN
    check({tag, "_csum"}, oFrameChecksum, 0);
`endif
  endtask

  task automatic take_event(input ev_kind_t k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: actual event at h=%0d v=%0d required none", nm, oHcounter, oVcounter);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, int'(k), int'(e.kind));
      check({nm, "_h"}, oHcounter, e.h);
      check({nm, "_v"}, oVcounter, e.v);
      if (k == EV_PV_RISE) check({nm, "_rgb"}, oVGA_RGB, e.rgb);
      if (k == EV_LOCK) begin
        check("lock_line_period", oLinePeriod, LINE);
        check("lock_hsync_width", oHsyncWidth, HPW);
        check("lock_frame_lines", oFrameLines, FLINES);
      end
    end
  endtask

  // monitor: every output event pops the next scoreboard entry
  initial begin
    logic pv_d, lk_d, err_chk;
    pv_d = 1'b0; lk_d = 1'b0; err_chk = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        pv_d = 1'b0; lk_d = 1'b0; err_chk = 1'b0;
      end else begin
        if (err_chk) begin
          check("unlock_after_err", oLocked, 0);
          err_chk = 1'b0;
        end
        if (oErr) begin
          take_event(EV_ERR, "err");
          err_chk = 1'b1;
        end
        if (oLocked && !lk_d) take_event(EV_LOCK, "lock");
        if (oPixelValid && !pv_d) take_event(EV_PV_RISE, "pv_rise");
        if (!oPixelValid && pv_d) take_event(EV_PV_FALL, "pv_fall");
        pv_d = oPixelValid;
        lk_d = oLocked;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    iHsync = 1'b1; iVsync = 1'b1; iVGA_RGB = RGB_BLACK;
    #1 Reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    // acquire lock: frames 1-2 measure/verify, lock at the Vsync rise starting frame 3
    pre_sync();
    gen_frame();
    gen_frame();
    push_ev(EV_LOCK, 0, 0, 0);
    exp_locked = 1'b1;
    exp_sum = 0;
    gen_frame();

    // frame 4: checksum of frame 3, then line 10 is one clock short
    gen_line(0, HHIGH, 1'b0);
`ifdef VGA_RX_CHECKSUM_EN
    check("csum_frame3", oFrameChecksum, exp_sum % 65536);
`endif
    for (int l = 1; l < FLINES; l++) begin
      if (l == 11) begin
        push_ev(EV_ERR, 0, 11, 0);
        exp_locked = 1'b0;
      end
      gen_line(l, (l == 10) ? HHIGH - 1 : HHIGH, 1'b0);
    end

    // two more good frames relock at the start of frame 7
    gen_frame();
    gen_frame();
    push_ev(EV_LOCK, 0, 0, 0);
    exp_locked = 1'b1;
    exp_sum = 0;
    gen_frame();
    gen_line(0, HHIGH, 1'b0);
`ifdef VGA_RX_CHECKSUM_EN
    check("csum_frame7", oFrameChecksum, exp_sum % 65536);
`endif
    for (int l = 1; l < 5; l++) gen_line(l, HHIGH, 1'b0);

    // reset in the middle of active line 5 while locked
    push_ev(EV_PV_RISE, HA0, 5, int'(pix(HA0, 5)));
    for (int c = 0; c < 20; c++) drive(1'b1, 1'b1, pix(c, 5));
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1 check_all_zero("mid_reset");
    exp_locked = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    // reacquire from scratch, then hold Hsync high past the counter limit
    pre_sync();
    gen_frame();
    gen_frame();
    push_ev(EV_LOCK, 0, 0, 0);
    exp_locked = 1'b1;
    for (int l = 0; l < 6; l++) gen_line(l, HHIGH, 1'b0);
    gen_line(6, 1100, 1'b1);
    gen_line(7, HHIGH, 1'b0);
    gen_line(8, HHIGH, 1'b0);
    repeat (5) @(negedge Clock);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Sink-side counterpart of the VGA timing generator: takes Hsync/Vsync/RGB on the pixel clock and recovers the H/V pixel position.
- Measures line period, Hsync pulse width and lines per frame, and declares lock once consecutive frames agree.
- Drives a registered pixel stream with an active-area valid flag.
- Sits on loopback and capture paths for self-check of the display pipeline.

Parameters:
- H_ACT_START, 48, first active column (counter 0 = first clock after Hsync rising edge)
- H_ACT_END, 687, last active column, inclusive
- V_ACT_START, 29, first active line
- V_ACT_END, 508, last active line, inclusive
- LOCK_FRAMES, 2, consecutive matching frames required to assert lock (1..3)

Ports:
- Clock  in  1  pixel clock, same domain as the generator
- Reset  in  1  asynchronous, active-high
- iHsync  in  1  horizontal sync, active-low pulse
- iVsync  in  1  vertical sync, active-low pulse
- iVGA_RGB  in  3  pixel colour {R,G,B}
- oHcounter  out  10  recovered column
- oVcounter  out  10  recovered line
- oVGA_RGB  out  3  iVGA_RGB delayed by 1 clock
- oPixelValid  out  1  recovered position is inside the active window and oLocked=1
- oLinePeriod  out  10  measured clocks per line
- oHsyncWidth  out  10  measured Hsync low clocks
- oFrameLines  out  10  measured lines per frame
- oLocked  out  1  timing stable
- oErr  out  1  one-clock pulse on timing mismatch or timeout

Behaviour:
- Interface rules (already decided): one clock; reset is asynchronous and active-high.
- Reset: every output is 0; the FSM is in SEARCH; edge-detect registers are 1 (sync idle high).
- Edge detection:
  - Hsync rise = iHsync=1 and previous sample 0; Vsync rise is defined the same way.
  - Hsync fall gives the pulse start, used for the width measurement.
- Latency: all outputs are registered. The oHcounter/oVcounter/oVGA_RGB state at edge t+1 reflects the generator's state at edge t.
- H counter:
  - Loads 0 on the cycle after an Hsync rise; otherwise increments.
  - Saturates at 1023 and raises a timeout.
- V counter:
  - Loads 0 on the Hsync rise that follows a Vsync rise.
  - Otherwise increments on each Hsync rise; saturates at 1023.
- Simultaneous Hsync and Vsync rise: H loads 0 and V loads 0 in the same cycle.
- FSM states:
  - SEARCH: wait for a Vsync rise, then go to MEASURE.
  - MEASURE:
    - On each Hsync rise, capture the line period, which is the H count reached plus 1.
    - On each Hsync rise, capture the Hsync width, counted from fall to rise.
    - At the next Vsync rise, capture frame lines (V count plus 1), set match_cnt=1 and go to VERIFY.
    - If LOCK_FRAMES=1, go directly to LOCKED instead.
  - VERIFY:
    - Each line's period and width are compared with the captured values.
    - At each Vsync rise, the frame line count is compared as well.
    - If every comparison matches, increment match_cnt; at LOCK_FRAMES go to LOCKED.
    - Any mismatch pulses oErr and returns to SEARCH.
  - LOCKED:
    - oLocked=1 and the same comparisons continue.
    - A mismatch or timeout pulses oErr, clears oLocked the next cycle and returns to SEARCH.
- Timeout: the H counter reaching 1023, or the V counter reaching 1023, in any state other than SEARCH is treated as a mismatch.
- oLinePeriod, oHsyncWidth and oFrameLines hold their last captured values; they are cleared only by Reset.
- oPixelValid = oLocked AND H_ACT_START<=oHcounter<=H_ACT_END AND V_ACT_START<=oVcounter<=V_ACT_END.
- Reset asserted mid-frame: immediate return to the reset state; lock is reacquired from scratch.

Optional Feature:
- Macro: VGA_RX_CHECKSUM_EN.
- Defined:
  - Adds output oFrameChecksum[15:0].
  - A 16-bit wrapping sum of {13'b0,RGB} over every cycle with oPixelValid=1.
  - Latched into oFrameChecksum at each Vsync rise while locked; the accumulator clears at the same time.
  - Reset value 0.
- Undefined: the port and logic are absent.

Decomposition:
- Shared package/include holds:
  - HS_Ts, HS_Tpw, HS_Tbp, HS_Tfp, VS_lines_* timing constants
  - FSM state encodings (SEARCH, MEASURE, VERIFY, LOCKED)
  - colour constants
- Sub-module vga_sync_edge_detect: one instance each for Hsync and Vsync; outputs rise/fall pulses; async reset to idle-high.

Test Plan:
- 640x480 generator timing (800 clk/line, 96 Hsync, 521 lines) for 3 frames:
  - oLinePeriod=800, oHsyncWidth=96, oFrameLines=521.
  - oLocked rises at the start of frame 3 (Vsync rise ending frame 2).
  - oErr never asserted.
- Locked, first active pixel: oPixelValid=1 exactly when oHcounter=48 and oVcounter=29. It drops at H=688, and at V=509.
- While locked, one line shortened to 799 clocks: oErr pulses 1 clock; oLocked=0 next cycle; relock after 2 more good frames.
- While locked, Hsync held high for 1100 clocks: timeout at H=1023, oErr pulse, FSM returns to SEARCH.
- Reset asserted mid-line while locked: all outputs 0 immediately, without waiting for a clock edge; measured values cleared.
- With VGA_RX_CHECKSUM_EN, constant RGB=3'b001 over a full active frame: oFrameChecksum=307200 mod 65536 = 0xB000.
